// File: rtl/axis_pack_pkg.sv
// Shared types and byte-enable helpers for AXI-Stream packing stages.
// Helpers take keeps zero-extended to MAX_N bytes so any beat width up to 64 bytes can reuse them.
// No state, no latency, no flow control.
package axis_pack_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } state_e;

    localparam int MAX_N = 64;

    function automatic logic [7:0] keep_popcount(input logic [MAX_N-1:0] keep);
        logic [7:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_N; i++) begin
            cnt = cnt + {7'b0, keep[i]};
        end
        return cnt;
    endfunction

    // A contiguous LSB-aligned keep is 2^k-1, so adding one clears every set bit.
    function automatic logic keep_is_contig(input logic [MAX_N-1:0] keep);
        return (keep & (keep + 1'b1)) == '0;
    endfunction

    function automatic logic [MAX_N-1:0] byte_mask(input logic [7:0] n);
        logic [MAX_N-1:0] m;
        for (int i = 0; i < MAX_N; i++) begin
            m[i] = (8'(i) < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_keep_count.sv
// Counts enabled bytes in a tkeep and flags whether they form one LSB-aligned run.
// Purely combinational, zero latency.
// No flow control; the caller qualifies the result with its own handshake.
module axis_keep_count #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  keep,
    output logic [CW-1:0] cnt,
    output logic          contig
);
    import axis_pack_pkg::*;

    logic [MAX_N-1:0] keep_ext;

    always_comb begin
        keep_ext         = '0;
        keep_ext[N-1:0]  = keep;
        cnt              = CW'(keep_popcount(keep_ext));
        contig           = keep_is_contig(keep_ext);
    end

endmodule

// File: rtl/axis_byte_packer.sv
// Concatenates LSB-aligned byte runs into dense beats; only a packet's last beat may be partial.
// Output is registered: 1 cycle from an accepting edge; packets overflowing on tlast add one flush beat.
// s_axis_tready follows the single output slot and drops for the flush cycle.
module axis_byte_packer #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 64
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [USER_WIDTH-1:0]   m_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    keep_err
);
    import axis_pack_pkg::*;

    localparam int N  = DATA_WIDTH / 8;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW:0] N_W = (CW + 1)'(N);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic [CW-1:0]           hold_cnt_q, hold_cnt_d;
    logic [USER_WIDTH-1:0]   pkt_user_q, pkt_user_d;
    logic                    first_q, first_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic [USER_WIDTH-1:0]   tuser_q, tuser_d;
    logic [N-1:0]            tkeep_q, tkeep_d;
    logic                    tlast_q, tlast_d;
    logic                    tvalid_q, tvalid_d;
    logic                    keep_err_q, keep_err_d;

    logic [CW-1:0]           k;
    logic                    contig;
    logic                    slot_free;
    logic                    accept;
    logic [N-1:0]            kmask;
    logic [DATA_WIDTH-1:0]   data_m;
    logic [2*DATA_WIDTH-1:0] comb;
    logic [CW:0]             total;
    logic [CW:0]             diff;
    logic [USER_WIDTH-1:0]   user_cur;

    axis_keep_count #(.N(N), .CW(CW)) u_keep_count (
        .keep   (s_axis_tkeep),
        .cnt    (k),
        .contig (contig)
    );

    assign slot_free     = !tvalid_q || m_axis_tready;
    assign s_axis_tready = (state_q == ACCUM) && slot_free;
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_comb begin
        // Bytes are taken by count, not by keep bit, so a malformed keep still yields k bytes.
        kmask = N'(byte_mask(8'(k)));
        for (int b = 0; b < N; b++) begin
            data_m[b*8 +: 8] = kmask[b] ? s_axis_tdata[b*8 +: 8] : 8'h00;
        end
        comb     = {{DATA_WIDTH{1'b0}}, hold_q} | ({{DATA_WIDTH{1'b0}}, data_m} << {hold_cnt_q, 3'b000});
        total    = {1'b0, hold_cnt_q} + {1'b0, k};
        diff     = total - N_W;
        user_cur = first_q ? s_axis_tuser : pkt_user_q;

        state_d    = state_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        pkt_user_d = pkt_user_q;
        first_d    = first_q;
        tdata_d    = tdata_q;
        tuser_d    = tuser_q;
        tkeep_d    = tkeep_q;
        tlast_d    = tlast_q;
        tvalid_d   = tvalid_q && !m_axis_tready;
        keep_err_d = keep_err_q;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (!contig) keep_err_d = 1'b1;
                    if (first_q) pkt_user_d = s_axis_tuser;
                    first_d = s_axis_tlast;
                    if (!s_axis_tlast && (total < N_W)) begin
                        hold_d     = comb[DATA_WIDTH-1:0];
                        hold_cnt_d = CW'(total);
                    end else begin
                        tvalid_d = 1'b1;
                        tdata_d  = comb[DATA_WIDTH-1:0];
                        tuser_d  = user_cur;
                        if (s_axis_tlast && (total <= N_W)) begin
                            tkeep_d    = N'(byte_mask(8'(total)));
                            tlast_d    = 1'b1;
                            hold_d     = '0;
                            hold_cnt_d = '0;
                        end else begin
                            tkeep_d    = '1;
                            tlast_d    = 1'b0;
                            hold_d     = comb[2*DATA_WIDTH-1:DATA_WIDTH];
                            hold_cnt_d = CW'(diff);
                            if (s_axis_tlast) state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    tvalid_d   = 1'b1;
                    tdata_d    = hold_q;
                    tuser_d    = pkt_user_q;
                    tkeep_d    = N'(byte_mask(8'(hold_cnt_q)));
                    tlast_d    = 1'b1;
                    hold_d     = '0;
                    hold_cnt_d = '0;
                    state_d    = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ACCUM;
            hold_q     <= '0;
            hold_cnt_q <= '0;
            pkt_user_q <= '0;
            first_q    <= 1'b1;
            tdata_q    <= '0;
            tuser_q    <= '0;
            tkeep_q    <= '0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            keep_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            pkt_user_q <= pkt_user_d;
            first_q    <= first_d;
            tdata_q    <= tdata_d;
            tuser_q    <= tuser_d;
            tkeep_q    <= tkeep_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
            keep_err_q <= keep_err_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign keep_err      = keep_err_q;

endmodule

// File: tb/tb_axis_byte_packer.sv
// Directed bench for axis_byte_packer (64-bit data): packing, flush bubble, stall, null packet,
// keep error stickiness and reset in the middle of a flush.
module tb_axis_byte_packer;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [63:0] user;
    } beat_t;

    logic        aclk;
    logic        aresetn;
    logic [63:0] s_tdata;
    logic [63:0] s_tuser;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [7:0]  s_tkeep;
    logic [63:0] m_tdata;
    logic [63:0] m_tuser;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [7:0]  m_tkeep;
    logic        keep_err;

    int checks = 0;
    int errors = 0;

    beat_t in_q[$];
    beat_t exp_q[$];
    beat_t got_q[$];
    int    got_cyc[$];
    int    nrdy_cnt, stall_cnt, stall_rdy_viol, stall_unstable;

    axis_byte_packer #(.DATA_WIDTH(64), .USER_WIDTH(64)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tkeep  (s_tkeep),
        .m_axis_tdata  (m_tdata),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tkeep  (m_tkeep),
        .keep_err      (keep_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic beat_t cur_out();
        beat_t b;
        b.data = m_tdata;
        b.keep = m_tkeep;
        b.last = m_tlast;
        b.user = m_tuser;
        return b;
    endfunction

    task automatic new_test();
        in_q.delete();
        exp_q.delete();
    endtask

    task automatic add_in(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [63:0] u);
        in_q.push_back('{data: d, keep: k, last: l, user: u});
    endtask

    task automatic add_exp(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [63:0] u);
        exp_q.push_back('{data: d, keep: k, last: l, user: u});
    endtask

    task automatic idle_inputs();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tkeep  = '0;
        s_tdata  = '0;
        s_tuser  = '0;
    endtask

    // Called at posedge+1; drives in_q, samples at negedge, stalls the sink once if asked.
    task automatic run_pkt(input int stall_req);
        int    idx;
        int    stall_left;
        bit    stalled_once;
        bit    done;
        beat_t held;
        idx = 0; stall_left = 0; stalled_once = 0; done = 0; held = '0;
        got_q.delete(); got_cyc.delete();
        nrdy_cnt = 0; stall_cnt = 0; stall_rdy_viol = 0; stall_unstable = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (idx < in_q.size()) begin
                s_tvalid = 1'b1;
                s_tdata  = in_q[idx].data;
                s_tkeep  = in_q[idx].keep;
                s_tlast  = in_q[idx].last;
                s_tuser  = in_q[idx].user;
            end else begin
                idle_inputs();
            end
            if (stall_req > 0 && !stalled_once && m_tvalid) begin
                stall_left   = stall_req;
                stalled_once = 1'b1;
                held         = cur_out();
            end
            m_tready = (stall_left == 0);
            @(negedge aclk);
            if (!s_tready) nrdy_cnt++;
            if (stall_left > 0) begin
                stall_cnt++;
                if (s_tready) stall_rdy_viol++;
                if (!m_tvalid || cur_out() != held) stall_unstable++;
                stall_left--;
            end
            if (m_tvalid && m_tready) begin
                got_q.push_back(cur_out());
                got_cyc.push_back(cyc);
            end
            if (s_tvalid && s_tready) idx++;
            @(posedge aclk);
            #1;
            if (idx == in_q.size() && !m_tvalid && s_tready) done = 1'b1;
        end
        check("run_done", {63'b0, done}, 64'd1);
        idle_inputs();
        m_tready = 1'b1;
    endtask

    task automatic cmp_beats(input string tag);
        check($sformatf("%s_nbeats", tag), 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s_b%0d_data", tag, i), got_q[i].data, exp_q[i].data);
                check($sformatf("%s_b%0d_keep", tag, i), {56'b0, got_q[i].keep}, {56'b0, exp_q[i].keep});
                check($sformatf("%s_b%0d_last", tag, i), {63'b0, got_q[i].last}, {63'b0, exp_q[i].last});
                check($sformatf("%s_b%0d_user", tag, i), got_q[i].user, exp_q[i].user);
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tvalid"}, {63'b0, m_tvalid}, 64'd0);
        check({tag, "_tdata"}, m_tdata, 64'd0);
        check({tag, "_tkeep"}, {56'b0, m_tkeep}, 64'd0);
        check({tag, "_tlast"}, {63'b0, m_tlast}, 64'd0);
        check({tag, "_tuser"}, m_tuser, 64'd0);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        idle_inputs();
        m_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic load_pkt_abc();
        new_test();
        add_in(64'hEEEE_A5A4_A3A2_A1A0, 8'h3F, 1'b0, 64'h1111);
        add_in(64'hEEEE_B5B4_B3B2_B1B0, 8'h3F, 1'b0, 64'h2222);
        add_in(64'hEEEE_EEEE_C3C2_C1C0, 8'h0F, 1'b1, 64'h3333);
        add_exp(64'hB1B0_A5A4_A3A2_A1A0, 8'hFF, 1'b0, 64'h1111);
        add_exp(64'hC3C2_C1C0_B5B4_B3B2, 8'hFF, 1'b1, 64'h1111);
    endtask

    initial begin
        aresetn = 1'b0;
        idle_inputs();
        m_tready = 1'b1;
        #3;
        check_outputs_zero("rst");
        check("rst_keep_err", {63'b0, keep_err}, 64'd0);
        check("rst_s_tready", {63'b0, s_tready}, 64'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // Three partial beats pack into two full beats back to back
        load_pkt_abc();
        run_pkt(0);
        cmp_beats("pack");
        if (got_cyc.size() >= 2) check("pack_no_bubble", 64'(got_cyc[1] - got_cyc[0]), 64'd1);

        // Residue overflow on tlast costs exactly one not-ready cycle
        new_test();
        add_in(64'hEEEE_EEEE_A3A2_A1A0, 8'h0F, 1'b0, 64'h4444);
        add_in(64'hB7B6_B5B4_B3B2_B1B0, 8'hFF, 1'b1, 64'h5555);
        add_exp(64'hB3B2_B1B0_A3A2_A1A0, 8'hFF, 1'b0, 64'h4444);
        add_exp(64'h0000_0000_B7B6_B5B4, 8'h0F, 1'b1, 64'h4444);
        run_pkt(0);
        cmp_beats("flush");
        check("flush_nrdy_cycles", 64'(nrdy_cnt), 64'd1);

        // Sink stall after the first output beat
        load_pkt_abc();
        run_pkt(5);
        cmp_beats("stall");
        check("stall_cycles", 64'(stall_cnt), 64'd5);
        check("stall_s_tready", 64'(stall_rdy_viol), 64'd0);
        check("stall_stable", 64'(stall_unstable), 64'd0);

        // Null packet
        new_test();
        add_in(64'hEEEE_EEEE_EEEE_EEEE, 8'h00, 1'b1, 64'h55);
        add_exp(64'h0, 8'h00, 1'b1, 64'h55);
        run_pkt(0);
        cmp_beats("null");
        check("null_keep_err", {63'b0, keep_err}, 64'd0);

        // Non-contiguous keep: two bytes counted, error goes sticky
        new_test();
        add_in(64'hEEEE_EEEE_EEEE_2211, 8'h05, 1'b1, 64'h66);
        add_exp(64'h2211, 8'h03, 1'b1, 64'h66);
        run_pkt(0);
        cmp_beats("badkeep");
        check("badkeep_err_set", {63'b0, keep_err}, 64'd1);

        new_test();
        add_in(64'h0807_0605_0403_0201, 8'hFF, 1'b1, 64'h77);
        add_exp(64'h0807_0605_0403_0201, 8'hFF, 1'b1, 64'h77);
        run_pkt(0);
        cmp_beats("legal");
        check("legal_err_sticky", {63'b0, keep_err}, 64'd1);

        // Reset asserted while the packer sits in FLUSH
        s_tvalid = 1'b1; s_tdata = 64'hEEEE_EEEE_A3A2_A1A0; s_tkeep = 8'h0F; s_tlast = 1'b0; s_tuser = 64'h99;
        @(posedge aclk);
        #1;
        s_tdata = 64'hB7B6_B5B4_B3B2_B1B0; s_tkeep = 8'hFF; s_tlast = 1'b1;
        @(posedge aclk);
        #1;
        idle_inputs();
        check("mid_flush_tvalid", {63'b0, m_tvalid}, 64'd1);
        check("mid_flush_s_tready", {63'b0, s_tready}, 64'd0);
        aresetn = 1'b0;
        #1;
        check_outputs_zero("arst");
        check("arst_keep_err", {63'b0, keep_err}, 64'd0);
        check("arst_s_tready", {63'b0, s_tready}, 64'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        new_test();
        add_in(64'h1817_1615_1413_1211, 8'hFF, 1'b1, 64'h88);
        add_exp(64'h1817_1615_1413_1211, 8'hFF, 1'b1, 64'h88);
        run_pkt(0);
        cmp_beats("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
